// File: rtl/com_op_code_dispatcher.sv
// rtl/com_op_code_dispatcher.sv - one-hot op-code dispatcher with edge-detected issue, timeout and sticky errors
module com_op_code_dispatcher #(
  parameter int N_OPS          = 16,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int IDX_W          = $clog2(N_OPS)
) (
  input  logic             fw_axi_clk,
  input  logic             fw_rst,
  input  logic             fw_dev_id_enable,
  input  logic [N_OPS-1:0] fw_op_code,
  input  logic             op_done,
  input  logic             status_clear,
  output logic [N_OPS-1:0] op_code,
  output logic [N_OPS-1:0] op_code_pulse,
  output logic [IDX_W-1:0] op_active_idx,
  output logic             op_busy,
  output logic             op_done_pulse,
  output logic             err_multi,
  output logic             err_overrun,
  output logic             err_timeout,
  output logic             err_abort
);

  localparam int CNT_RAW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CNT_W   = (CNT_RAW < 1) ? 1 : CNT_RAW;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  localparam int E_MULTI   = 0;
  localparam int E_OVERRUN = 1;
  localparam int E_TIMEOUT = 2;
  localparam int E_ABORT   = 3;

  typedef enum logic {S_IDLE, S_ACTIVE} state_e;

  state_e           state_q, state_d;
  logic [N_OPS-1:0] fw_op_code_q;
  logic [N_OPS-1:0] op_code_q, op_code_d;
  logic [N_OPS-1:0] pulse_q, pulse_d;
  logic [IDX_W-1:0] idx_q, idx_d, rise_idx;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_pulse_q, done_pulse_d;
  logic [3:0]       err_q, err_d, err_set;
  logic             armed_q;

  logic [N_OPS-1:0] rise;
  logic             rise_any, rise_one, rise_multi, timeout_hit;

  assign rise        = fw_op_code & ~fw_op_code_q;
  assign rise_any    = |rise;
  assign rise_one    = rise_any && ((rise & (rise - N_OPS'(1))) == '0);
  assign rise_multi  = rise_any && !rise_one;
  assign timeout_hit = (TIMEOUT_CYCLES > 0) && (cnt_q == TO_LAST);

  always_comb begin
    rise_idx = '0;
    for (int i = 0; i < N_OPS; i++) begin
      if (rise[i]) rise_idx = IDX_W'(i);
    end
  end

  always_comb begin
    state_d      = state_q;
    op_code_d    = op_code_q;
    pulse_d      = '0;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    done_pulse_d = 1'b0;
    err_set      = '0;
    case (state_q)
      S_IDLE: begin
        // armed_q masks the first post-reset cycle so levels held through reset never issue
        if (armed_q && fw_dev_id_enable) begin
          if (rise_one) begin
            state_d   = S_ACTIVE;
            op_code_d = rise;
            pulse_d   = rise;
            idx_d     = rise_idx;
            cnt_d     = '0;
          end else if (rise_multi) begin
            err_set[E_MULTI] = 1'b1;
          end
        end
      end
      S_ACTIVE: begin
        err_set[E_OVERRUN] = rise_any;
        if (!fw_dev_id_enable || op_done || timeout_hit) begin
          state_d   = S_IDLE;
          op_code_d = '0;
          idx_d     = '0;
          if (!fw_dev_id_enable)  err_set[E_ABORT]   = 1'b1;
          else if (op_done)       done_pulse_d       = 1'b1;
          else                    err_set[E_TIMEOUT] = 1'b1;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d   = S_IDLE;
        op_code_d = '0;
        idx_d     = '0;
      end
    endcase
    err_d = err_set | (err_q & {4{~status_clear}});
  end

  always_ff @(posedge fw_axi_clk) begin
    if (fw_rst) begin
      state_q      <= S_IDLE;
      fw_op_code_q <= '0;
      op_code_q    <= '0;
      pulse_q      <= '0;
      idx_q        <= '0;
      cnt_q        <= '0;
      done_pulse_q <= 1'b0;
      err_q        <= '0;
      armed_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      fw_op_code_q <= fw_op_code;
      op_code_q    <= op_code_d;
      pulse_q      <= pulse_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      done_pulse_q <= done_pulse_d;
      err_q        <= err_d;
      armed_q      <= 1'b1;
    end
  end

  assign op_code       = op_code_q;
  assign op_code_pulse = pulse_q;
  assign op_active_idx = idx_q;
  assign op_busy       = (state_q == S_ACTIVE);
  assign op_done_pulse = done_pulse_q;
  assign err_multi     = err_q[E_MULTI];
  assign err_overrun   = err_q[E_OVERRUN];
  assign err_timeout   = err_q[E_TIMEOUT];
  assign err_abort     = err_q[E_ABORT];

endmodule

// File: tb/tb_com_op_code_dispatcher.sv
// tb/tb_com_op_code_dispatcher.sv - scoreboard bench with cycle-level reference model
module tb_com_op_code_dispatcher;

  localparam int N  = 16;
  localparam int TO = 8;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic [N-1:0]  op_in = '0;
  logic          done_in = 1'b0;
  logic          clr_in = 1'b0;
  logic [N-1:0]  op_code, op_code_pulse;
  logic [IW-1:0] op_active_idx;
  logic          op_busy, op_done_pulse, err_multi, err_overrun, err_timeout, err_abort;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  com_op_code_dispatcher #(.N_OPS(N), .TIMEOUT_CYCLES(TO)) dut (
    .fw_axi_clk(clk), .fw_rst(rst), .fw_dev_id_enable(en), .fw_op_code(op_in),
    .op_done(done_in), .status_clear(clr_in), .op_code(op_code), .op_code_pulse(op_code_pulse),
    .op_active_idx(op_active_idx), .op_busy(op_busy), .op_done_pulse(op_done_pulse),
    .err_multi(err_multi), .err_overrun(err_overrun), .err_timeout(err_timeout), .err_abort(err_abort)
  );

  // Reference model state: what the outputs should look like after the next clock edge
  bit           m_active = 0, m_armed = 0, m_donep = 0;
  bit           m_multi = 0, m_ovr = 0, m_to = 0, m_abort = 0;
  logic [N-1:0] m_op = '0, m_pulse = '0, m_prev = '0;
  int           m_idx = 0, m_cnt = 0;

  logic [41:0] exp_q[$];

  function automatic logic [41:0] snapshot();
    return {m_op, m_pulse, 4'(m_idx), m_active, m_donep, m_multi, m_ovr, m_to, m_abort};
  endfunction

  task automatic model(input logic e, input logic [N-1:0] o, input logic d, input logic c, input logic r);
    logic [N-1:0] rs;
    bit s_multi, s_ovr, s_to, s_abort;
    if (r) begin
      m_active = 0; m_armed = 0; m_donep = 0; m_op = '0; m_pulse = '0; m_prev = '0;
      m_idx = 0; m_cnt = 0; m_multi = 0; m_ovr = 0; m_to = 0; m_abort = 0;
      return;
    end
    rs = o & ~m_prev;
    m_prev = o;
    m_pulse = '0; m_donep = 0;
    s_multi = 0; s_ovr = 0; s_to = 0; s_abort = 0;
    if (!m_armed) begin
      m_armed = 1;
    end else if (!m_active) begin
      if (e && rs != 0) begin
        if ($countones(rs) == 1) begin
          m_active = 1; m_op = rs; m_pulse = rs; m_idx = $clog2(rs); m_cnt = 0;
        end else s_multi = 1;
      end
    end else begin
      if (rs != 0) s_ovr = 1;
      if (!e || d || m_cnt == TO - 1) begin
        if (!e) s_abort = 1;
        else if (d) m_donep = 1;
        else s_to = 1;
        m_active = 0; m_op = '0; m_idx = 0;
      end else m_cnt++;
    end
    m_multi = s_multi || (m_multi && !c);
    m_ovr   = s_ovr   || (m_ovr && !c);
    m_to    = s_to    || (m_to && !c);
    m_abort = s_abort || (m_abort && !c);
  endtask

  task automatic step(input logic e, input logic [N-1:0] o, input logic d = 0,
                      input logic c = 0, input logic r = 0);
    @(negedge clk);
    en = e; op_in = o; done_in = d; clr_in = c; rst = r;
    model(e, o, d, c, r);
    exp_q.push_back(snapshot());
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  initial begin : monitor
    logic [41:0] e, g;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        g = {op_code, op_code_pulse, op_active_idx, op_busy, op_done_pulse,
             err_multi, err_overrun, err_timeout, err_abort};
        checks++;
        if (g !== e) begin
          failures++;
          $display("FAIL outputs t=%0t got=%h expected=%h", $time, g, e);
        end
      end
    end
  end

  initial begin : driver
    logic [N-1:0] cur;
    step(0, '0, 0, 0, 1);
    step(0, '0, 0, 0, 1);
    settle();
    chk("reset_outputs", {op_code, op_code_pulse, 8'(op_active_idx)}, 32'h0);
    chk("reset_flags", {op_busy, op_done_pulse, err_multi, err_overrun, err_timeout, err_abort}, 0);
    step(1, '0);
    step(1, '0);

    // single issue, completion
    step(1, 16'h0020);
    settle();
    chk("issue_op_code", op_code, 32'h20);
    chk("issue_idx", op_active_idx, 5);
    chk("issue_pulse", op_code_pulse, 32'h20);
    step(1, 16'h0020);
    settle();
    chk("pulse_one_cycle", op_code_pulse, 0);
    step(1, 16'h0020);
    step(1, 16'h0020, 1);
    settle();
    chk("done_pulse", op_done_pulse, 1);
    chk("done_clears_busy", {op_busy, op_code}, 0);
    step(1, '0);
    settle();
    chk("done_pulse_one_cycle", op_done_pulse, 0);

    // multi-rise error and clear
    step(1, 16'h0003);
    settle();
    chk("multi_flag", err_multi, 1);
    chk("multi_no_busy", op_busy, 0);
    step(1, '0, 0, 1);
    settle();
    chk("multi_cleared", err_multi, 0);

    // timeout
    step(1, 16'h0001);
    for (int i = 0; i < 7; i++) step(1, 16'h0001);
    settle();
    chk("still_busy_before_timeout", op_busy, 1);
    step(1, 16'h0001);
    settle();
    chk("timeout_flag", err_timeout, 1);
    chk("timeout_clears", {op_busy, op_done_pulse, op_code}, 0);
    step(1, '0, 0, 1);

    // overrun
    step(1, 16'h0004);
    step(1, 16'h0104);
    settle();
    chk("overrun_flag", err_overrun, 1);
    chk("overrun_keeps_op", op_code, 32'h4);
    step(1, 16'h0104, 1);
    settle();
    chk("overrun_then_done", op_done_pulse, 1);
    step(1, '0, 0, 1);

    // abort wins over done, then reset mid-op
    step(1, 16'h8000);
    step(1, 16'h8000);
    step(0, 16'h8000, 1);
    settle();
    chk("abort_flag", err_abort, 1);
    chk("abort_no_done_pulse", op_done_pulse, 0);
    step(1, '0, 0, 1);
    step(1, 16'h8000);
    step(1, 16'h8000, 0, 0, 1);
    settle();
    chk("reset_mid_op", {op_code, op_busy, op_done_pulse, err_multi, err_overrun, err_timeout, err_abort}, 0);
    step(1, 16'h8000);
    step(1, 16'h8000);
    settle();
    chk("held_level_no_issue", op_busy, 0);
    step(1, '0);

    // randomized traffic
    cur = '0;
    for (int n = 0; n < 2000; n++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 30) cur[$urandom_range(0, N - 1)] ^= 1'b1;
      else if (r < 36) cur = cur | (N'(1) << $urandom_range(0, N - 1)) | (N'(1) << $urandom_range(0, N - 1));
      else if (r < 46) cur = '0;
      step($urandom_range(0, 19) != 0, cur, $urandom_range(0, 5) == 0,
           $urandom_range(0, 19) == 0, $urandom_range(0, 199) == 0);
    end
    step(1, cur);
    repeat (3) @(posedge clk);
    #3;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
